vdp_seq_ctrl: RTL and testbench

Sequencing controller for the 64-bit vector datapath, driven by the MCU. It runs three kinds of command:
- single-cycle ALU operations;
- two-beat 64-bit loads from the 32-bit memory bus (lo word, hi word, regfile writeback);
- two-beat 64-bit stores to the same bus.
It drives the datapath's select and enable controls and its register addresses, owns the memory request/acknowledge handshake, and reports done, busy and error back to the MCU.

---
 rtl/vdp_ctrl_pkg.sv | 16 +
 rtl/vdp_ack_timer.sv | 21 ++
 rtl/vdp_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_vdp_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_ctrl_pkg.sv
// vdp_ctrl_pkg: shared encodings for the vector datapath sequencing controller.
//   op_t    - MCU command opcodes
//   state_t - controller FSM states
//   FS_PASS_S_DEF - default VALU function code that passes S straight to Y
package vdp_ctrl_pkg;
  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;
  typedef enum logic [3:0] {
    IDLE, ALU, ST_EVAL, ST_LO, ST_HI, LD_LO, LD_HI, LD_WB, DONE
  } state_t;
  localparam logic [4:0] FS_PASS_S_DEF = 5'h00;
endpackage

// File: rtl/vdp_ack_timer.sv
// vdp_ack_timer: per-beat wait counter with terminal-count flag.
//   CLK, RESET (sync, active-low) - clock and reset
//   clr - zero the count (entry to a new beat)
//   en  - count this cycle (request outstanding, no ack)
//   tc  - count has reached TIMEOUT-1
module vdp_ack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK)
    if (!RESET || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/vdp_seq_ctrl.sv
// vdp_seq_ctrl: sequences ALU, 2-beat 64-bit load and 2-beat 64-bit store commands.
//   CLK, RESET (sync, active-low)
//   start/op/fs_in/d_in/s_in/t_in/use_imm/base_addr - MCU command, latched in IDLE
//   mem_ack - memory beat complete
//   FS, D_Addr, S_Addr, T_Addr, D_EN, T_Sel, DIN_Sel, DOut_Sel, Y_Sel - datapath controls
//   mem_req, mem_wr, mem_addr - memory bus request
//   busy, done, err - status to MCU
// All outputs are decoded from registered state only, so no input reaches an output
// combinationally.
module vdp_seq_ctrl
  import vdp_ctrl_pkg::*;
#(
  parameter int         TIMEOUT   = 16,
  parameter logic [4:0] FS_PASS_S = FS_PASS_S_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  fs_in,
  input  logic [4:0]  d_in,
  input  logic [4:0]  s_in,
  input  logic [4:0]  t_in,
  input  logic        use_imm,
  input  logic [31:0] base_addr,
  input  logic        mem_ack,
  output logic [4:0]  FS,
  output logic [4:0]  D_Addr,
  output logic [4:0]  S_Addr,
  output logic [4:0]  T_Addr,
  output logic        D_EN,
  output logic        T_Sel,
  output logic        DIN_Sel,
  output logic        DOut_Sel,
  output logic        Y_Sel,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t      state, nxt;
  logic        imm_q, err_q, err_d, tc, req, hi;
  logic [31:0] base_q;
  always_ff @(posedge CLK)
    if (!RESET) begin
      state  <= IDLE;
      FS     <= '0;
      D_Addr <= '0;
      S_Addr <= '0;
      T_Addr <= '0;
      imm_q  <= 1'b0;
      base_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= err_d;
      if (state == IDLE && start) begin
        // A store forces the pass-through function so Y holds the source register.
        FS     <= (op == OP_STORE) ? FS_PASS_S : fs_in;
        D_Addr <= d_in;
        S_Addr <= s_in;
        T_Addr <= t_in;
        imm_q  <= use_imm;
        base_q <= base_addr;
      end
    end
  always_comb begin
    nxt   = state;
    err_d = (state == IDLE) ? 1'b0 : err_q;
    case (state)
      IDLE:
        if (start) begin
          if ((op == OP_LOAD || op == OP_STORE) && base_addr[1:0] != 2'b00) begin
            nxt   = DONE;
            err_d = 1'b1;
          end else if (op == OP_ALU) nxt = ALU;
          else if (op == OP_LOAD) nxt = LD_LO;
          else if (op == OP_STORE) nxt = ST_EVAL;
          else nxt = DONE;
        end
      ALU:     nxt = DONE;
      ST_EVAL: nxt = ST_LO;
      ST_LO, ST_HI, LD_LO, LD_HI:
        // An ack on the terminal-count cycle still completes the beat.
        if (mem_ack) begin
          if (state == ST_LO) nxt = ST_HI;
          else if (state == LD_LO) nxt = LD_HI;
          else if (state == LD_HI) nxt = LD_WB;
          else nxt = DONE;
        end else if (tc) begin
          nxt   = DONE;
          err_d = 1'b1;
        end
      LD_WB:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  vdp_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (nxt != state),
    .en    (req && !mem_ack),
    .tc    (tc)
  );
  assign req      = state == ST_LO || state == ST_HI || state == LD_LO || state == LD_HI;
  assign hi       = state == ST_HI || state == LD_HI;
  assign mem_req  = req;
  assign mem_wr   = state == ST_LO || state == ST_HI;
  assign mem_addr = req ? (hi ? base_q + 32'd4 : base_q) : 32'd0;
  assign D_EN     = state == ALU || state == LD_WB;
  assign T_Sel    = state == ALU && imm_q;
  assign Y_Sel    = state == LD_WB;
  // DIN_Sel stays high through writeback so the lo buffer is not overwritten.
  assign DIN_Sel  = state == LD_HI || state == LD_WB;
  assign DOut_Sel = state == ST_HI;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign err      = state == DONE && err_q;
endmodule

// File: tb/tb_vdp_seq_ctrl.sv
// tb_vdp_seq_ctrl: randomized scoreboard bench for vdp_seq_ctrl with a small datapath/memory environment.
module tb_vdp_seq_ctrl;
  import vdp_ctrl_pkg::*;
  localparam int TIMEOUT = 16;
  localparam logic [4:0] PASS = 5'h00;
  localparam logic [1:0] K_BEAT = 2'd0, K_WR = 2'd1, K_DONE = 2'd2;
  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] a;
    logic        w;
    logic [63:0] v;
    logic [11:0] x;
  } ev_t;
  logic CLK = 1'b0, RESET = 1'b0, start = 1'b0, use_imm = 1'b0, mem_ack = 1'b0;
  logic [1:0] op = 2'b00;
  logic [4:0] fs_in = '0, d_in = '0, s_in = '0, t_in = '0;
  logic [31:0] base_addr = '0;
  logic [4:0] FS, D_Addr, S_Addr, T_Addr;
  logic D_EN, T_Sel, DIN_Sel, DOut_Sel, Y_Sel, mem_req, mem_wr, busy, done, err;
  logic [31:0] mem_addr;
  vdp_seq_ctrl #(.TIMEOUT(TIMEOUT), .FS_PASS_S(PASS)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op(op), .fs_in(fs_in), .d_in(d_in),
    .s_in(s_in), .t_in(t_in), .use_imm(use_imm), .base_addr(base_addr), .mem_ack(mem_ack),
    .FS(FS), .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr), .D_EN(D_EN), .T_Sel(T_Sel),
    .DIN_Sel(DIN_Sel), .DOut_Sel(DOut_Sel), .Y_Sel(Y_Sel), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .busy(busy), .done(done), .err(err)
  );
  always #5 CLK = ~CLK;
  int compared = 0, mismatched = 0, cyc = 0;
  ev_t exp_q[$];
  logic [63:0] rf [32], pre [32], ref_rf [32];
  logic [63:0] y_reg = '0, tval, yv;
  logic [31:0] lo_buf = '0, hi_buf = '0, DY = '0, dt = 32'h1357_9BDF, d_out;
  logic load_rf = 1'b0;
  int dly [2];
  logic [31:0] dat [2];
  int beat_idx = 2, wcnt = 0;
  function automatic logic [63:0] alu(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
    return f == PASS ? a : a + b + 64'(f);
  endfunction
  // environment: regfile, VALU, Y register, load buffers
  assign tval  = T_Sel ? {32'b0, dt} : rf[T_Addr];
  assign yv    = Y_Sel ? {hi_buf, lo_buf} : alu(FS, rf[S_Addr], tval);
  assign d_out = DOut_Sel ? y_reg[63:32] : y_reg[31:0];
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    y_reg <= alu(FS, rf[S_Addr], tval);
    if (load_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= pre[i];
    end else if (D_EN) rf[D_Addr] <= yv;
    if (mem_req && mem_ack && !mem_wr) begin
      if (DIN_Sel) hi_buf <= DY;
      else lo_buf <= DY;
    end
  end
  // memory responder: acks beat n after dly[n] wait cycles
  initial forever begin
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    if (mem_req && beat_idx < 2) begin
      if (wcnt == dly[beat_idx]) begin
        mem_ack = 1'b1;
        DY = dat[beat_idx];
        beat_idx++;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end
  task automatic got(input ev_t a);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got k=%0d a=%h w=%b v=%h x=%h, required none", a.k, a.a, a.w, a.v, a.x);
      return;
    end
    e = exp_q.pop_front();
    if (a !== e) begin
      mismatched++;
      $display("FAIL event_k%0d: got k=%0d a=%h w=%b v=%h x=%h, required k=%0d a=%h w=%b v=%h x=%h",
               e.k, a.k, a.a, a.w, a.v, a.x, e.k, e.a, e.w, e.v, e.x);
    end
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  // monitor
  initial forever begin
    @(negedge CLK);
    if (mem_req && mem_ack) got('{K_BEAT, mem_addr, mem_wr, mem_wr ? {32'b0, d_out} : {32'b0, DY}, 12'b0});
    if (D_EN) got('{K_WR, {27'b0, D_Addr}, 1'b0, yv, {S_Addr, T_Addr, T_Sel, Y_Sel}});
    if (done) got('{K_DONE, 32'(cyc), err, 64'b0, 12'b0});
    if (D_EN && mem_req) chk("den_during_req", 1, 0);
    if (done && !busy) chk("done_not_busy", 1, 0);
  end
  function automatic logic [61:0] outs();
    return {FS, D_Addr, S_Addr, T_Addr, D_EN, T_Sel, DIN_Sel, DOut_Sel, Y_Sel,
            mem_req, mem_wr, mem_addr, busy, done, err};
  endfunction
  task automatic issue(input logic [1:0] o, input logic [4:0] f, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic im, input logic [31:0] b,
                       input int d0, input int d1, input logic [31:0] x0, input logic [31:0] x1);
    int k, lat, n;
    logic ok0, ok1, e;
    logic [63:0] v;
    @(posedge CLK); #1;
    dly[0] = d0; dly[1] = d1; dat[0] = x0; dat[1] = x1; beat_idx = 0;
    op = o; fs_in = f; d_in = d; s_in = s; t_in = t; use_imm = im; base_addr = b; start = 1'b1;
    k = cyc;
    ok0 = d0 < TIMEOUT;
    ok1 = d1 < TIMEOUT;
    e = 1'b0;
    if ((o == OP_LOAD || o == OP_STORE) && b[1:0] != 2'b00) begin
      lat = 1; e = 1'b1;
    end else if (o == OP_NOP) lat = 1;
    else if (o == OP_ALU) begin
      v = alu(f, ref_rf[s], im ? {32'b0, dt} : ref_rf[t]);
      exp_q.push_back('{K_WR, {27'b0, d}, 1'b0, v, {s, t, im, 1'b0}});
      ref_rf[d] = v;
      lat = 2;
    end else begin
      lat = (o == OP_STORE) ? 1 : 0;
      lat += ok0 ? d0 + 1 : TIMEOUT;
      if (ok0) begin
        exp_q.push_back('{K_BEAT, b, o == OP_STORE, o == OP_STORE ? {32'b0, ref_rf[s][31:0]} : {32'b0, x0}, 12'b0});
        lat += ok1 ? d1 + 1 : TIMEOUT;
        if (ok1)
          exp_q.push_back('{K_BEAT, b + 32'd4, o == OP_STORE, o == OP_STORE ? {32'b0, ref_rf[s][63:32]} : {32'b0, x1}, 12'b0});
      end
      e = !(ok0 && ok1);
      if (o == OP_LOAD && !e) begin
        exp_q.push_back('{K_WR, {27'b0, d}, 1'b0, {x1, x0}, {s, t, 1'b0, 1'b1}});
        ref_rf[d] = {x1, x0};
        lat += 1;
      end
      lat += 1;
    end
    exp_q.push_back('{K_DONE, 32'(k + lat), e, 64'b0, 12'b0});
    @(posedge CLK); #1;
    n = 0;
    // junk on the command inputs while busy must be ignored
    while (!done && n < 100) begin
      start = 1'($urandom); op = 2'($urandom); fs_in = 5'($urandom); d_in = 5'($urandom);
      s_in = 5'($urandom); t_in = 5'($urandom); use_imm = 1'($urandom); base_addr = $urandom;
      @(posedge CLK); #1;
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask
  function automatic int rdly();
    int r;
    r = $urandom_range(0, 11);
    return r < 7 ? r % 4 : r == 7 ? TIMEOUT - 1 : r == 8 ? TIMEOUT : 1;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] o;
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      pre[i] = {$urandom, $urandom};
      ref_rf[i] = pre[i];
    end
    pre[5] = 64'hDEAD_BEEF_CAFE_F00D;
    ref_rf[5] = pre[5];
    load_rf = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    load_rf = 1'b0;
    chk("reset_outputs", 64'(outs()), 0);
    RESET = 1'b1;
    issue(OP_ALU, 5'h02, 5'd3, 5'd1, 5'd2, 1'b0, 32'h0, 0, 0, 0, 0);
    issue(OP_LOAD, 5'h00, 5'd7, 5'd0, 5'd0, 1'b0, 32'h100, 2, 2, 32'h89AB_CDEF, 32'h0123_4567);
    issue(OP_STORE, 5'h09, 5'd0, 5'd5, 5'd0, 1'b0, 32'h200, 0, 1, 0, 0);
    issue(OP_LOAD, 5'h00, 5'd8, 5'd1, 5'd2, 1'b0, 32'h400, TIMEOUT, 0, 32'h1111_1111, 32'h2222_2222);
    issue(OP_LOAD, 5'h00, 5'd9, 5'd1, 5'd2, 1'b0, 32'h102, 0, 0, 0, 0);
    issue(OP_STORE, 5'h00, 5'd0, 5'd4, 5'd0, 1'b0, 32'h201, 0, 0, 0, 0);
    issue(OP_LOAD, 5'h00, 5'd10, 5'd3, 5'd4, 1'b0, 32'h500, TIMEOUT - 1, TIMEOUT - 1, 32'hAAAA_5555, 32'h5555_AAAA);
    issue(OP_STORE, 5'h00, 5'd0, 5'd6, 5'd0, 1'b0, 32'h600, 0, TIMEOUT, 0, 0);
    issue(OP_LOAD, 5'h00, 5'd11, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFC, 1, 0, 32'hCAFE_0001, 32'hCAFE_0002);
    issue(OP_STORE, 5'h00, 5'd0, 5'd11, 5'd0, 1'b0, 32'hFFFF_FFFC, 0, 3, 0, 0);
    issue(OP_NOP, 5'h00, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 0, 0, 0, 0);
    issue(OP_ALU, 5'h07, 5'd12, 5'd13, 5'd14, 1'b1, 32'h0, 0, 0, 0, 0);
    // reset in the middle of the hi beat of a load
    @(posedge CLK); #1;
    dly[0] = 0; dly[1] = 40; dat[0] = 32'h7777_0000; dat[1] = 32'h7777_1111; beat_idx = 0;
    op = OP_LOAD; d_in = 5'd9; s_in = 5'd0; t_in = 5'd0; base_addr = 32'h300; start = 1'b1;
    exp_q.push_back('{K_BEAT, 32'h300, 1'b0, {32'b0, 32'h7777_0000}, 12'b0});
    @(posedge CLK); #1;
    start = 1'b0;
    for (int n = 0; n < 20 && !(mem_req && mem_addr == 32'h304); n++) begin
      @(posedge CLK); #1;
    end
    chk("reach_ld_hi", {63'b0, mem_req && mem_addr == 32'h304}, 1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("midcmd_reset_outputs", 64'(outs()), 0);
    RESET = 1'b1;
    chk("midcmd_reset_queue", 64'(exp_q.size()), 0);
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom);
      b = $urandom;
      if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) b = 32'hFFFF_FFFC;
      issue(o, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), b,
            rdly(), rdly(), $urandom, $urandom);
    end
    repeat (5) @(posedge CLK);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_r%0d", i), rf[i], ref_rf[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
